// File: rtl/pipe_drain_arbiter_if.sv
// Requester-side bundle for the pipe drain arbiter: level requests, done pulses,
// one-hot grants and pipe hold/stopped status.
interface pipe_drain_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] grant;
   logic [2:0]       grant_id;
   logic             pipe_hold;
   logic             pipe_stopped;
   logic             timeout_err;

   modport master (
      output req, done,
      input  grant, grant_id, pipe_hold, pipe_stopped, timeout_err
   );

   modport slave (
      input  req, done,
      output grant, grant_id, pipe_hold, pipe_stopped, timeout_err
   );
endinterface

// File: rtl/pipe_drain_arbiter.sv
// Round-robin arbiter granting exclusive datapath access after holding the pipe
// input for a fixed drain time; handoffs between requesters skip the re-drain.
module pipe_drain_arbiter #(
   parameter int N_REQ         = 4,
   parameter int DRAIN_CYCLES  = 15,
   parameter int GRANT_TIMEOUT = 256
) (
   input  logic                i_clock,
   input  logic                i_reset,
   pipe_drain_arbiter_if.slave io_arb
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int TO_W    = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(GRANT_TIMEOUT - 1);
   localparam logic [2:0]         LAST_IDX   = 3'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_GRANT,
      S_RELEASE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_winner;
   logic [2:0]         w_winner_nxt;
   logic [2:0]         r_ptr;
   logic [2:0]         w_ptr_nxt;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [DRAIN_W-1:0] w_drain_cnt_nxt;
   logic [TO_W-1:0]    r_to_cnt;
   logic [TO_W-1:0]    w_to_cnt_nxt;
   logic               r_timeout_err;
   logic               w_timeout_err_nxt;

   logic [N_REQ-1:0]   w_win_onehot;
   logic [2:0]         w_rr_pick;
   logic               w_any_req;
   logic               w_win_req;
   logic               w_win_done;
   logic               w_to_hit;

   // First set request at or after the pointer, wrapping modulo N_REQ.
   function automatic logic [2:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [2:0]       ptr);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && req[idx]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [2:0] f_next_ptr(input logic [2:0] winner);
      return (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
   endfunction

   assign w_win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_winner;
   assign w_rr_pick    = f_rr_pick(io_arb.req, r_ptr);
   assign w_any_req    = |io_arb.req;
   assign w_win_req    = |(io_arb.req & w_win_onehot);
   assign w_win_done   = |(io_arb.done & w_win_onehot);
   assign w_to_hit     = (GRANT_TIMEOUT != 0) && (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt       = r_state;
      w_winner_nxt      = r_winner;
      w_ptr_nxt         = r_ptr;
      w_drain_cnt_nxt   = r_drain_cnt;
      w_to_cnt_nxt      = r_to_cnt;
      w_timeout_err_nxt = r_timeout_err;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_winner_nxt    = w_rr_pick;
               w_drain_cnt_nxt = DRAIN_LOAD;
               w_state_nxt     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A requester that gave up while draining forfeits its turn.
            if (r_drain_cnt == '0) begin
               if (w_win_req) begin
                  w_to_cnt_nxt = '0;
                  w_state_nxt  = S_GRANT;
               end else begin
                  w_ptr_nxt    = f_next_ptr(r_winner);
                  w_state_nxt  = S_RELEASE;
               end
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - DRAIN_W'(1);
            end
         end
         S_GRANT: begin
            if (w_win_done || !w_win_req || w_to_hit) begin
               w_ptr_nxt   = f_next_ptr(r_winner);
               w_state_nxt = S_RELEASE;
               // A timeout only counts as an error when nothing else ended the grant.
               if (w_to_hit && !w_win_done && w_win_req) begin
                  w_timeout_err_nxt = 1'b1;
               end
            end else if (GRANT_TIMEOUT != 0) begin
               w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
         end
         S_RELEASE: begin
            if (w_any_req) begin
               w_winner_nxt = w_rr_pick;
               w_to_cnt_nxt = '0;
               w_state_nxt  = S_GRANT;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_winner      <= 3'd0;
         r_ptr         <= 3'd0;
         r_drain_cnt   <= '0;
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_winner      <= w_winner_nxt;
         r_ptr         <= w_ptr_nxt;
         r_drain_cnt   <= w_drain_cnt_nxt;
         r_to_cnt      <= w_to_cnt_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   // Outputs decode only registered state, so reset clears them immediately.
   assign io_arb.pipe_hold    = (r_state != S_IDLE);
   assign io_arb.pipe_stopped = (r_state == S_GRANT) || (r_state == S_RELEASE);
   assign io_arb.grant        = (r_state == S_GRANT) ? w_win_onehot : '0;
   assign io_arb.grant_id     = r_winner;
   assign io_arb.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_pipe_drain_arbiter.sv
// Directed bench for pipe_drain_arbiter: drain latency, round-robin handoff,
// drain abort, grant timeout and asynchronous reset.
module tb_pipe_drain_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pipe_drain_arbiter_if #(.N_REQ(4)) arb_if ();

   pipe_drain_arbiter #(
      .N_REQ        (4),
      .DRAIN_CYCLES (15),
      .GRANT_TIMEOUT(8)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .io_arb (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic hold, input logic stop,
                         input logic [3:0] gnt);
      chk({tag, ".hold"},  8'(arb_if.pipe_hold),    8'(hold));
      chk({tag, ".stop"},  8'(arb_if.pipe_stopped), 8'(stop));
      chk({tag, ".grant"}, 8'(arb_if.grant),        8'(gnt));
   endtask

   logic [3:0] order [5];

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      arb_if.req  = 4'b0000;
      arb_if.done = 4'b0000;
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      order[3] = 4'b1000;
      order[4] = 4'b0001;
      tick();
      tick();
      chk_st("reset", 1'b0, 1'b0, 4'b0000);
      chk("reset.id",  8'(arb_if.grant_id),    8'd0);
      chk("reset.err", 8'(arb_if.timeout_err), 8'd0);
      rst = 1'b0;
      tick();

      // Single request: 15-cycle drain, grant, ignored foreign done, release.
      arb_if.req = 4'b0001;
      tick();
      chk_st("t1.e0", 1'b1, 1'b0, 4'b0000);
      repeat (14) begin
         tick();
         chk_st("t1.drain", 1'b1, 1'b0, 4'b0000);
      end
      tick();
      chk_st("t1.grant", 1'b1, 1'b1, 4'b0001);
      chk("t1.id", 8'(arb_if.grant_id), 8'd0);
      arb_if.done = 4'b1000;
      tick();
      arb_if.done = 4'b0000;
      chk_st("t6.ignored", 1'b1, 1'b1, 4'b0001);
      tick();
      chk_st("t6.still", 1'b1, 1'b1, 4'b0001);
      arb_if.done = 4'b0001;
      arb_if.req  = 4'b0000;
      tick();
      arb_if.done = 4'b0000;
      chk_st("t1.release", 1'b1, 1'b1, 4'b0000);
      tick();
      chk_st("t1.idle", 1'b0, 1'b0, 4'b0000);

      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();

      // All four requesting: one drain, then round-robin handoffs with 1-cycle gaps.
      arb_if.req = 4'b1111;
      tick();
      chk_st("t2.e0", 1'b1, 1'b0, 4'b0000);
      repeat (14) tick();
      tick();
      chk_st("t2.first", 1'b1, 1'b1, order[0]);
      for (int k = 0; k < 5; k++) begin
         chk("t2.id", 8'(arb_if.grant_id), 8'(k % 4));
         tick();
         chk_st("t2.c2", 1'b1, 1'b1, order[k]);
         tick();
         chk_st("t2.c3", 1'b1, 1'b1, order[k]);
         arb_if.done = order[k];
         if (k == 4) arb_if.req = 4'b0000;
         tick();
         arb_if.done = 4'b0000;
         chk_st("t2.gap", 1'b1, 1'b1, 4'b0000);
         if (k < 4) begin
            tick();
            chk_st("t2.next", 1'b1, 1'b1, order[k+1]);
         end
      end
      tick();
      chk_st("t2.idle", 1'b0, 1'b0, 4'b0000);

      // Request withdrawn mid-drain: no grant, pointer moves past it.
      arb_if.req = 4'b0100;
      tick();
      chk_st("t3.e0", 1'b1, 1'b0, 4'b0000);
      chk("t3.id", 8'(arb_if.grant_id), 8'd2);
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 3) arb_if.req = 4'b0000;
         chk_st("t3.drain", 1'b1, 1'b0, 4'b0000);
      end
      tick();
      chk_st("t3.release", 1'b1, 1'b1, 4'b0000);
      tick();
      chk_st("t3.idle", 1'b0, 1'b0, 4'b0000);
      arb_if.req = 4'b1111;
      tick();
      repeat (14) tick();
      tick();
      chk_st("t3.grant", 1'b1, 1'b1, 4'b1000);
      chk("t3.id2", 8'(arb_if.grant_id), 8'd3);
      arb_if.done = 4'b1000;
      arb_if.req  = 4'b0000;
      tick();
      arb_if.done = 4'b0000;
      tick();
      chk_st("t3.idle2", 1'b0, 1'b0, 4'b0000);

      // Grant held past the 8-cycle limit is revoked and flags the error.
      arb_if.req = 4'b0010;
      tick();
      repeat (14) tick();
      tick();
      chk_st("t4.grant", 1'b1, 1'b1, 4'b0010);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk_st("t4.hold", 1'b1, 1'b1, 4'b0010);
         chk("t4.err0", 8'(arb_if.timeout_err), 8'd0);
      end
      tick();
      chk_st("t4.revoked", 1'b1, 1'b1, 4'b0000);
      chk("t4.err1", 8'(arb_if.timeout_err), 8'd1);
      tick();
      chk_st("t4.regrant", 1'b1, 1'b1, 4'b0010);
      arb_if.req = 4'b0000;
      tick();
      chk_st("t4.release", 1'b1, 1'b1, 4'b0000);
      tick();
      chk_st("t4.idle", 1'b0, 1'b0, 4'b0000);
      chk("t4.sticky", 8'(arb_if.timeout_err), 8'd1);
      rst = 1'b1;
      #1;
      chk("t4.err_clr", 8'(arb_if.timeout_err), 8'd0);
      rst = 1'b0;
      tick();

      // done coincides with the terminal count: no error.
      arb_if.req = 4'b0010;
      tick();
      repeat (14) tick();
      tick();
      chk_st("t4b.grant", 1'b1, 1'b1, 4'b0010);
      repeat (7) tick();
      chk_st("t4b.c8", 1'b1, 1'b1, 4'b0010);
      arb_if.done = 4'b0010;
      arb_if.req  = 4'b0000;
      tick();
      arb_if.done = 4'b0000;
      chk_st("t4b.release", 1'b1, 1'b1, 4'b0000);
      chk("t4b.err", 8'(arb_if.timeout_err), 8'd0);
      tick();
      chk_st("t4b.idle", 1'b0, 1'b0, 4'b0000);

      // Asynchronous reset mid-drain and mid-grant; held request re-drains fully.
      arb_if.req = 4'b0001;
      tick();
      repeat (4) tick();
      chk_st("t5.drain5", 1'b1, 1'b0, 4'b0000);
      rst = 1'b1;
      #1;
      chk_st("t5.rst_drain", 1'b0, 1'b0, 4'b0000);
      #1;
      rst = 1'b0;
      tick();
      chk_st("t5.e0", 1'b1, 1'b0, 4'b0000);
      repeat (14) begin
         tick();
         chk_st("t5.drain", 1'b1, 1'b0, 4'b0000);
      end
      tick();
      chk_st("t5.grant", 1'b1, 1'b1, 4'b0001);
      tick();
      rst = 1'b1;
      #1;
      chk_st("t5.rst_grant", 1'b0, 1'b0, 4'b0000);
      chk("t5.rst_id", 8'(arb_if.grant_id), 8'd0);
      rst = 1'b0;
      tick();
      chk_st("t5.e0b", 1'b1, 1'b0, 4'b0000);
      repeat (14) tick();
      chk_st("t5.late", 1'b1, 1'b0, 4'b0000);
      tick();
      chk_st("t5.grant2", 1'b1, 1'b1, 4'b0001);
      arb_if.done = 4'b0001;
      arb_if.req  = 4'b0000;
      tick();
      arb_if.done = 4'b0000;
      tick();
      chk_st("t5.idle", 1'b0, 1'b0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
